// File: rtl/cmult_twiddle_pipe_pkg.sv
// Shared FFT datapath definitions: default widths, rounding modes, complex sample type and
// saturation bound helpers.
package fft_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned TW_W_DEF = 8;

    localparam int unsigned ROUND_TRUNC = 0;
    localparam int unsigned ROUND_HALF_UP = 1;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

    function automatic logic signed [63:0] SAT_MAX(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] SAT_MIN(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/cmult_twiddle_pipe_if.sv
// Handshake and data bundle for the twiddle multiplier: input sample/twiddle side, result side
// and overflow status.
interface cmult_twiddle_pipe_if import fft_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TW_W   = TW_W_DEF
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic signed [TW_W-1:0]   w_re;
    logic signed [TW_W-1:0]   w_im;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic                     out_ovf;
    logic                     ovf_clr;
    logic                     ovf_sticky;

    modport master (
        output in_valid, in_re, in_im, w_re, w_im, out_ready, ovf_clr,
        input  in_ready, out_valid, out_re, out_im, out_ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, in_re, in_im, w_re, w_im, out_ready, ovf_clr,
        output in_ready, out_valid, out_re, out_im, out_ovf, ovf_sticky
    );

endinterface

// File: rtl/cmult_twiddle_pipe_sat_round_shift.sv
// Rounds, arithmetically shifts and clamps one signed component back to the output width,
// flagging when the clamp engaged.
module sat_round_shift import fft_pkg::*; #(
    parameter int unsigned IN_W  = 25,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 7,
    parameter int unsigned ROUND = ROUND_HALF_UP
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic signed [OUT_W-1:0] val_o,
    output logic                    ovf_o
);

    // One guard bit so adding the rounding bias can never wrap.
    localparam int unsigned EXT_W = IN_W + 1;

    localparam logic signed [EXT_W-1:0] BIAS =
        (ROUND == ROUND_HALF_UP) ? (EXT_W'(1) << (SHIFT - 1)) : EXT_W'(0);
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(SAT_MAX(OUT_W));
    localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(SAT_MIN(OUT_W));

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        biased  = EXT_W'(val_i) + BIAS;
        shifted = biased >>> SHIFT;
        val_o   = shifted[OUT_W-1:0];
        ovf_o   = 1'b0;
        if (shifted > MAX_V) begin
            val_o = MAX_V[OUT_W-1:0];
            ovf_o = 1'b1;
        end else if (shifted < MIN_V) begin
            val_o = MIN_V[OUT_W-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/cmult_twiddle_pipe.sv
// Three-stage pipelined signed complex multiplier (sample x twiddle) with valid/ready flow
// control, selectable rounding and saturating output with sticky overflow.
module cmult_twiddle_pipe import fft_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TW_W   = TW_W_DEF,
    parameter int unsigned ROUND  = ROUND_HALF_UP
) (
    input logic               clk,
    input logic               rst_n,
    cmult_twiddle_pipe_if.slave bus
);

    localparam int unsigned PROD_W = DATA_W + TW_W;
    localparam int unsigned SUM_W  = PROD_W + 1;

    logic                     adv;
    logic                     s1_valid_q, s2_valid_q, s3_valid_q;
    logic signed [DATA_W-1:0] s1_re_q, s1_im_q;
    logic signed [TW_W-1:0]   s1_wr_q, s1_wi_q;
    logic signed [PROD_W-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [SUM_W-1:0]  sre, sim;
    logic signed [DATA_W-1:0] re_sat, im_sat;
    logic                     re_ovf, im_ovf;
    logic signed [DATA_W-1:0] out_re_q, out_im_q;
    logic                     out_ovf_q;
    logic                     ovf_sticky_q, ovf_sticky_d;

    // Whole pipe moves in lockstep; a stalled output freezes every stage.
    assign adv          = bus.out_ready || !s3_valid_q;
    assign bus.in_ready = adv;

    assign sre = SUM_W'(rr_q) - SUM_W'(ii_q);
    assign sim = SUM_W'(ri_q) + SUM_W'(ir_q);

    sat_round_shift #(
        .IN_W  (SUM_W),
        .OUT_W (DATA_W),
        .SHIFT (TW_W - 1),
        .ROUND (ROUND)
    ) u_sat_re (
        .val_i (sre),
        .val_o (re_sat),
        .ovf_o (re_ovf)
    );

    sat_round_shift #(
        .IN_W  (SUM_W),
        .OUT_W (DATA_W),
        .SHIFT (TW_W - 1),
        .ROUND (ROUND)
    ) u_sat_im (
        .val_i (sim),
        .val_o (im_sat),
        .ovf_o (im_ovf)
    );

    // Set has priority so an overflow landing with a clear is never lost.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (s3_valid_q && bus.out_ready && out_ovf_q) begin
            ovf_sticky_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            s1_re_q      <= '0;
            s1_im_q      <= '0;
            s1_wr_q      <= '0;
            s1_wi_q      <= '0;
            rr_q         <= '0;
            ii_q         <= '0;
            ri_q         <= '0;
            ir_q         <= '0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            out_ovf_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            if (adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_re_q <= bus.in_re;
                    s1_im_q <= bus.in_im;
                    s1_wr_q <= bus.w_re;
                    s1_wi_q <= bus.w_im;
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    rr_q <= PROD_W'(s1_re_q) * PROD_W'(s1_wr_q);
                    ii_q <= PROD_W'(s1_im_q) * PROD_W'(s1_wi_q);
                    ri_q <= PROD_W'(s1_re_q) * PROD_W'(s1_wi_q);
                    ir_q <= PROD_W'(s1_im_q) * PROD_W'(s1_wr_q);
                end
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    out_re_q  <= re_sat;
                    out_im_q  <= im_sat;
                    out_ovf_q <= re_ovf | im_ovf;
                end
            end
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign bus.out_valid  = s3_valid_q;
    assign bus.out_re     = out_re_q;
    assign bus.out_im     = out_im_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_cmult_twiddle_pipe.sv
// Directed and table-driven bench for cmult_twiddle_pipe; a rounding and a truncating instance
// see identical stimulus and are checked against hand values and a small reference model.
module tb_cmult_twiddle_pipe;
    import fft_pkg::*;

    localparam int unsigned DW  = 16;
    localparam int unsigned TWW = 8;

    typedef struct {
        int re, im, wr, wi;
        int re1, im1, re0, im0;
        int ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmult_twiddle_pipe_if #(.DATA_W(DW), .TW_W(TWW)) bus1 ();
    cmult_twiddle_pipe_if #(.DATA_W(DW), .TW_W(TWW)) bus0 ();

    cmult_twiddle_pipe #(.DATA_W(DW), .TW_W(TWW), .ROUND(ROUND_HALF_UP)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    cmult_twiddle_pipe #(.DATA_W(DW), .TW_W(TWW), .ROUND(ROUND_TRUNC)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    assign bus0.in_valid  = bus1.in_valid;
    assign bus0.in_re     = bus1.in_re;
    assign bus0.in_im     = bus1.in_im;
    assign bus0.w_re      = bus1.w_re;
    assign bus0.w_im      = bus1.w_im;
    assign bus0.out_ready = bus1.out_ready;
    assign bus0.ovf_clr   = bus1.ovf_clr;

    int checks = 0;
    int failures = 0;

    vec_t vecs[7];
    int   st_re[20], st_im[20], st_wr[20], st_wi[20];
    int   n_in, n_out, cyc;
    bit   in_x, out_x, stalled;
    int   held_re, held_im, held_ovf;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic cplx_t model(input longint re, input longint im, input longint wr,
                                    input longint wi, input bit rnd, output bit ovf);
        longint s[2];
        longint v;
        cplx_t  r;
        s[0] = re * wr - im * wi;
        s[1] = re * wi + im * wr;
        ovf = 1'b0;
        r = '0;
        for (int k = 0; k < 2; k++) begin
            v = s[k] + (rnd ? (64'sd1 <<< (TWW - 2)) : 64'sd0);
            v = v >>> (TWW - 1);
            if (v > 32767) begin
                v = 32767;
                ovf = 1'b1;
            end else if (v < -32768) begin
                v = -32768;
                ovf = 1'b1;
            end
            if (k == 0) r.re = v[15:0];
            else        r.im = v[15:0];
        end
        return r;
    endfunction

    task automatic drive(input int re, input int im, input int wr, input int wi);
        bus1.in_re = 16'(re);
        bus1.in_im = 16'(im);
        bus1.w_re  = 8'(wr);
        bus1.w_im  = 8'(wi);
    endtask

    task automatic chk_out(input int re, input int im, input int wr, input int wi);
        cplx_t e1, e0;
        bit    o1, o0;
        e1 = model(re, im, wr, wi, 1'b1, o1);
        e0 = model(re, im, wr, wi, 1'b0, o0);
        chk("model_re_r1", bus1.out_re, e1.re);
        chk("model_im_r1", bus1.out_im, e1.im);
        chk("model_ovf_r1", bus1.out_ovf, o1);
        chk("model_valid_r0", bus0.out_valid, 1);
        chk("model_re_r0", bus0.out_re, e0.re);
        chk("model_im_r0", bus0.out_im, e0.im);
        chk("model_ovf_r0", bus0.out_ovf, o0);
    endtask

    // Single transfer with out_ready high; returns at the cycle out_valid first shows.
    task automatic send_one(input int re, input int im, input int wr, input int wi);
        int lat;
        drive(re, im, wr, wi);
        bus1.in_valid  = 1'b1;
        bus1.out_ready = 1'b1;
        #1;
        chk("in_ready", bus1.in_ready, 1);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        lat = 1;
        while (!bus1.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 3);
    endtask

    initial begin
        vecs[0] = '{16384, 0, 127, 0, 16256, 0, 16256, 0, 0};
        vecs[1] = '{100, 200, 64, -64, 150, 50, 150, 50, 0};
        vecs[2] = '{3, 0, 64, 0, 2, 0, 1, 0, 0};
        vecs[3] = '{-3, 0, 64, 0, -1, 0, -2, 0, 0};
        vecs[4] = '{1000, -1000, -100, 50, -391, 1172, -391, 1171, 0};
        vecs[5] = '{-32768, -32768, 127, -128, -32768, 256, -32768, 256, 1};
        vecs[6] = '{32767, 32767, 127, -128, 32767, -256, 32767, -256, 1};

        rst_n          = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        bus1.ovf_clr   = 1'b0;
        drive(0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #11;
        chk("rst_out_valid", bus1.out_valid, 0);
        chk("rst_out_re", bus1.out_re, 0);
        chk("rst_out_im", bus1.out_im, 0);
        chk("rst_out_ovf", bus1.out_ovf, 0);
        chk("rst_sticky", bus1.ovf_sticky, 0);
        chk("rst_in_ready", bus1.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            send_one(vecs[i].re, vecs[i].im, vecs[i].wr, vecs[i].wi);
            chk("tbl_re_r1", bus1.out_re, vecs[i].re1);
            chk("tbl_im_r1", bus1.out_im, vecs[i].im1);
            chk("tbl_ovf_r1", bus1.out_ovf, vecs[i].ovf);
            chk("tbl_re_r0", bus0.out_re, vecs[i].re0);
            chk("tbl_im_r0", bus0.out_im, vecs[i].im0);
            chk("tbl_ovf_r0", bus0.out_ovf, vecs[i].ovf);
        end

        // Saturating table outputs transfer on this edge.
        @(posedge clk); #1;
        chk("sticky_from_tbl", bus1.ovf_sticky, 1);
        chk("sticky_from_tbl_r0", bus0.ovf_sticky, 1);
        bus1.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus1.ovf_clr = 1'b0;
        chk("sticky_clr_a", bus1.ovf_sticky, 0);

        send_one(-32768, 0, -128, 0);
        chk("sat_re_r1", bus1.out_re, 32767);
        chk("sat_im_r1", bus1.out_im, 0);
        chk("sat_ovf_r1", bus1.out_ovf, 1);
        chk("sat_re_r0", bus0.out_re, 32767);
        chk("sat_ovf_r0", bus0.out_ovf, 1);
        chk("sticky_before_xfer", bus1.ovf_sticky, 0);
        @(posedge clk); #1;
        chk("sticky_set", bus1.ovf_sticky, 1);
        bus1.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus1.ovf_clr = 1'b0;
        chk("sticky_clr_b", bus1.ovf_sticky, 0);

        send_one(-32768, 0, -128, 0);
        chk("sat2_ovf", bus1.out_ovf, 1);
        chk("sat2_sticky_pre", bus1.ovf_sticky, 0);
        bus1.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus1.ovf_clr = 1'b0;
        chk("sticky_set_wins", bus1.ovf_sticky, 1);
        chk("sticky_set_wins_r0", bus0.ovf_sticky, 1);

        // Random stream under random backpressure.
        for (int i = 0; i < 20; i++) begin
            st_re[i] = int'($urandom_range(0, 65535)) - 32768;
            st_im[i] = int'($urandom_range(0, 65535)) - 32768;
            st_wr[i] = int'($urandom_range(0, 255)) - 128;
            st_wi[i] = int'($urandom_range(0, 255)) - 128;
        end
        n_in = 0;
        n_out = 0;
        cyc = 0;
        stalled = 1'b0;
        held_re = 0;
        held_im = 0;
        held_ovf = 0;
        while (n_out < 20 && cyc < 400) begin
            if (n_in < 20) begin
                drive(st_re[n_in], st_im[n_in], st_wr[n_in], st_wi[n_in]);
                bus1.in_valid = 1'b1;
            end else begin
                bus1.in_valid = 1'b0;
            end
            bus1.out_ready = 1'($urandom_range(0, 1));
            #1;
            in_x  = bus1.in_valid && bus1.in_ready;
            out_x = bus1.out_valid && bus1.out_ready;
            if (stalled) begin
                chk("stall_hold_re", bus1.out_re, held_re);
                chk("stall_hold_im", bus1.out_im, held_im);
                chk("stall_hold_ovf", bus1.out_ovf, held_ovf);
            end
            stalled = bus1.out_valid && !bus1.out_ready;
            if (stalled) begin
                chk("stall_in_ready", bus1.in_ready, 0);
                held_re  = int'(bus1.out_re);
                held_im  = int'(bus1.out_im);
                held_ovf = int'(bus1.out_ovf);
            end
            if (out_x) begin
                if (n_out < 20) chk_out(st_re[n_out], st_im[n_out], st_wr[n_out], st_wi[n_out]);
                n_out++;
            end
            @(posedge clk); #1;
            if (in_x) n_in++;
            cyc++;
        end
        chk("stream_count", n_out, 20);
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_no_dup", bus1.out_valid, 0);

        // Reset with three samples in flight.
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(-32768, 0, -128, 0);
            else        drive(1000 * k, -2000, 50, 60);
            bus1.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        chk("pre_rst_valid", bus1.out_valid, 1);
        chk("pre_rst_ovf", bus1.out_ovf, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus1.out_valid, 0);
        chk("mid_rst_re", bus1.out_re, 0);
        chk("mid_rst_im", bus1.out_im, 0);
        chk("mid_rst_ovf", bus1.out_ovf, 0);
        chk("mid_rst_sticky", bus1.ovf_sticky, 0);
        chk("mid_rst_valid_r0", bus0.out_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("no_stale", bus1.out_valid, 0);
        end
        send_one(500, -700, 90, 30);
        chk("post_rst_re_r1", bus1.out_re, 516);
        chk("post_rst_im_r1", bus1.out_im, -375);
        chk_out(500, -700, 90, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmult_twiddle_pipe.md
Name: cmult_twiddle_pipe

Overview:
- Pipelined signed complex multiplier for the FFT butterfly: computes the product of one data sample and one twiddle factor per cycle.
  - out = (in_re + j·in_im) × (w_re + j·w_im), scaled back to the data format.
- Adds the following over the earlier combinational signed multiplier:
  - parametrised widths;
  - valid/ready flow control;
  - selectable rounding;
  - saturation with overflow reporting.
- Sits between the twiddle ROM and the butterfly add/sub stage.

Parameters:
- DATA_W, 16, data width; format Q1.(DATA_W-1), two's complement.
- TW_W, 8, twiddle width; format Q1.(TW_W-1), two's complement.
- ROUND, 1, rounding mode. 0 = truncate (arithmetic floor). 1 = round-half-up: add 2^(TW_W-2) before the shift.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept an input this cycle
- in_re  in  DATA_W  data, real part
- in_im  in  DATA_W  data, imaginary part
- w_re  in  TW_W  twiddle, real part
- w_im  in  TW_W  twiddle, imaginary part
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_re  out  DATA_W  result, real part
- out_im  out  DATA_W  result, imaginary part
- out_ovf  out  1  this result saturated (either component)
- ovf_clr  in  1  synchronous clear of ovf_sticky
- ovf_sticky  out  1  set by any accepted saturated output

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits = 0; out_valid = 0;
  - out_re = out_im = 0; out_ovf = 0; ovf_sticky = 0;
  - in-flight samples are discarded; no output for them after release.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Data and twiddle are sampled together in the same transfer.
- Pipeline: three stages, each with its own valid bit.
  - S1: register inputs.
  - S2: four signed products, each DATA_W+TW_W bits: rr = re·wr, ii = im·wi, ri = re·wi, ir = im·wr.
  - S3: sums, rounding, shift, saturation; registers the output.
  - Sums are DATA_W+TW_W+1 bits, sign-extended: sre = rr − ii, sim = ri + ir.
- Latency:
  - Exactly 3 cycles from input transfer to out_valid, with out_ready held high.
  - Throughput is 1 sample per cycle.
- Stall rule:
  - adv = out_ready || !out_valid.
  - When adv = 0, all stages hold.
  - in_ready = adv, combinational; there is no bubble collapsing.
  - Outputs are stable while out_valid && !out_ready.
- Scaling:
  - ROUND=0: s >>> (TW_W−1).
  - ROUND=1: (s + 2^(TW_W−2)) >>> (TW_W−1).
  - The shift is arithmetic.
- Saturation:
  - Shifted value > 2^(DATA_W−1)−1 → clamp to max.
  - Shifted value < −2^(DATA_W−1) → clamp to min.
  - out_ovf = OR of both component clamps, registered with the output.
- ovf_sticky:
  - Set on an output transfer with out_ovf = 1.
  - ovf_clr clears it.
  - If clear and set occur in the same cycle, set wins.
- Corner cases:
  - (−1)×(−1) saturates to +max.
  - A twiddle of +1.0 is not representable; the table uses (2^(TW_W−1)−1)/2^(TW_W−1).
- Back-to-back transfers with out_ready toggling every cycle lose and duplicate no sample.
- Sample order is preserved.

Decomposition:
- Shared package fft_pkg:
  - DATA_W and TW_W defaults;
  - ROUND_TRUNC = 0 and ROUND_HALF_UP = 1;
  - complex sample struct {re, im};
  - SAT_MAX and SAT_MIN helper functions.
- One sub-module, sat_round_shift: parametrised round + arithmetic shift + clamp of a single component.
  - Outputs the value and an ovf bit.
  - Instantiated twice in S3.

Test Plan (DATA_W=16, TW_W=8):
- Identity-ish: in = (16384, 0), w = (127, 0), ROUND=1 → after 3 cycles out = (16256, 0), out_ovf = 0.
- Complex: in = (100, 200), w = (64, −64) → out = (150, 50).
- Rounding, ROUND=1:
  - in = (3, 0), w = (64, 0) → out_re = 2.
  - in = (−3, 0) → out_re = −1.
- Rounding, ROUND=0, same inputs → out_re = 1 and −2.
- Saturation: in = (−32768, 0), w = (−128, 0) → out_re = 32767, out_ovf = 1, ovf_sticky = 1.
  - Then pulse ovf_clr → ovf_sticky = 0.
  - Pulse ovf_clr again in the same cycle as a new saturating output transfer → ovf_sticky stays 1.
- Backpressure:
  - Stream 20 random samples with random out_ready (~50%).
  - Expect outputs in order, matching the golden model, with no loss or duplicates.
  - While out_valid && !out_ready, out_* are stable and in_ready = 0.
- Reset mid-stream:
  - Assert rst_n low with 3 samples in flight.
  - Expect out_valid = 0 and outputs = 0 immediately.
  - After release, no stale outputs; the first new sample appears 3 cycles after its transfer.
